// File: rtl/program_memory.sv
// program_memory: instruction store with a checksummed, atomically committed byte-stream loader
module program_memory #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] RESET_WORD = 8'hF0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              cpu_reset,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_error
);
  typedef enum logic [2:0] {RUN, LOAD, CHECK, COMMIT, RELEASE} state_t;
  state_t state, next_state;
  logic [DATA_W-1:0] live [DEPTH];
  logic [DATA_W-1:0] staging [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] sum, chk_sum;
  logic xfer, last, ok;
  always_comb begin
    data = live[addr];
    ld_ready = state == LOAD || state == CHECK;
    ld_busy = state != RUN;
    ld_done = state == RELEASE;
    xfer = ld_valid && ld_ready;
    last = idx == ADDR_W'(DEPTH - 1);
    chk_sum = sum + ld_data;
    ok = chk_sum == '0;
    next_state = state == RUN   ? (ld_start ? LOAD : RUN) :
                 state == LOAD  ? (xfer && last ? CHECK : LOAD) :
                 state == CHECK ? (xfer ? (ok ? COMMIT : RELEASE) : CHECK) :
                 state == COMMIT ? RELEASE : RUN;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= RUN;
      idx <= '0;
      sum <= '0;
      cpu_reset <= 1'b0;
      ld_error <= 1'b0;
      for (int i = 0; i < DEPTH; i++) live[i] <= RESET_WORD;
    end else begin
      state <= next_state;
      cpu_reset <= next_state == RUN;
      if (state == RUN && ld_start) begin
        idx <= '0;
        sum <= '0;
        ld_error <= 1'b0;
      end
      if (state == LOAD && xfer) begin
        sum <= chk_sum;
        idx <= idx + 1'b1;
      end
      if (state == CHECK && xfer && !ok) ld_error <= 1'b1;
      if (state == COMMIT) live <= staging;
    end
  end
  always_ff @(posedge clock) begin
    if (state == LOAD && xfer) staging[idx] <= ld_data;
  end
endmodule

// File: tb/tb_program_memory.sv
// tb_program_memory: directed checks of reset, good/bad/gapped loads, reset mid-load and ignored ld_start
module tb_program_memory;
  logic clock = 1'b0;
  logic reset, ld_start, ld_valid;
  logic [3:0] addr;
  logic [7:0] data, ld_data;
  logic cpu_reset, ld_ready, ld_busy, ld_done, ld_error;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  program_memory dut (
    .clock(clock), .reset(reset), .addr(addr), .data(data), .cpu_reset(cpu_reset),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_busy(ld_busy), .ld_done(ld_done), .ld_error(ld_error)
  );
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] img(input int i, input bit pat);
    logic [3:0] n;
    n = 4'(i);
    return pat ? {n, n} : {4'h0, n};
  endfunction
  // mode 0/1 = image pattern, 2 = reset fill
  task automatic check_image(input logic [1:0] mode, input string tag);
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      @(negedge clock);
      chk(tag, data, mode == 2 ? 8'hF0 : img(i, mode[0]));
    end
    tick();
  endtask
  task automatic do_load(input bit pat, input logic [7:0] csum, input int gap, input bit poke,
                         input bit pass, input string tag);
    int rdy = 0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk({tag, "_busy"}, ld_busy, 1);
    chk({tag, "_cpu_reset_load"}, cpu_reset, 0);
    for (int i = 0; i < 17; i++) begin
      for (int g = 0; g < gap; g++) begin
        ld_valid = 1'b0;
        rdy += int'(ld_ready);
        tick();
      end
      ld_valid = 1'b1;
      ld_data = i < 16 ? img(i, pat) : csum;
      ld_start = poke && i == 4;
      rdy += int'(ld_ready);
      tick();
    end
    ld_valid = 1'b0;
    ld_start = 1'b0;
    if (gap == 0) chk({tag, "_ready_cycles"}, 8'(rdy), 8'd17);
    chk({tag, "_cpu_reset_end"}, cpu_reset, 0);
    if (pass) begin
      chk({tag, "_commit_ready"}, ld_ready, 0);
      chk({tag, "_commit_done"}, ld_done, 0);
      chk({tag, "_commit_busy"}, ld_busy, 1);
      tick();
      chk({tag, "_release_cpu_reset"}, cpu_reset, 0);
    end
    chk({tag, "_done"}, ld_done, 1);
    chk({tag, "_error"}, ld_error, pass ? 0 : 1);
    tick();
    chk({tag, "_done_low"}, ld_done, 0);
    chk({tag, "_run_busy"}, ld_busy, 0);
    chk({tag, "_run_cpu_reset"}, cpu_reset, 1);
  endtask
  initial begin
    reset = 1'b0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_data = 8'h00;
    addr = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_cpu_reset", cpu_reset, 0);
      chk("rst_ready", ld_ready, 0);
      chk("rst_busy", ld_busy, 0);
      chk("rst_done", ld_done, 0);
      chk("rst_error", ld_error, 0);
    end
    check_image(2, "rst_image");
    reset = 1'b1;
    chk("rel_cpu_reset_first", cpu_reset, 0);
    tick();
    chk("rel_cpu_reset_second", cpu_reset, 1);
    do_load(1'b0, 8'h88, 0, 1'b0, 1'b1, "good");
    addr = 4'd5;
    #1 chk("good_addr5", data, 8'h05);
    addr = 4'd15;
    #1 chk("good_addr15", data, 8'h0F);
    check_image(0, "good_image");
    do_load(1'b0, 8'h00, 0, 1'b0, 1'b0, "bad");
    tick();
    tick();
    chk("bad_error_sticky", ld_error, 1);
    check_image(0, "bad_image");
    ld_valid = 1'b1;
    ld_data = 8'hAA;
    chk("run_ready", ld_ready, 0);
    tick();
    tick();
    chk("run_valid_busy", ld_busy, 0);
    ld_valid = 1'b0;
    check_image(0, "run_valid_image");
    do_load(1'b1, 8'h08, 2, 1'b0, 1'b1, "gap");
    check_image(1, "gap_image");
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ld_valid = 1'b1;
      ld_data = img(i, 1'b0);
      tick();
    end
    ld_valid = 1'b0;
    chk("mid_busy_before", ld_busy, 1);
    reset = 1'b0;
    tick();
    chk("mid_busy", ld_busy, 0);
    chk("mid_ready", ld_ready, 0);
    chk("mid_cpu_reset", cpu_reset, 0);
    reset = 1'b1;
    tick();
    chk("mid_cpu_reset_rel", cpu_reset, 1);
    check_image(2, "mid_image");
    do_load(1'b0, 8'h88, 0, 1'b1, 1'b1, "poke");
    check_image(0, "poke_image");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
